// File: rtl/fft_sdf_butterfly.sv
// ---------------------------------------------------------------------------
// fft_sdf_butterfly
//   One radix-2 single-path delay-feedback (SDF) stage of a streaming FFT.
//   Each frame is 2*DELAY accepted samples long:
//     phase 0 (first DELAY samples): the incoming sample is parked in the
//       feedback delay line, and the difference left there by the previous
//       frame is rotated by the twiddle W and emitted.
//     phase 1 (last DELAY samples): the parked sample and the incoming sample
//       form a butterfly. The sum is emitted, and the difference is pushed
//       back into the delay line for rotation during the next phase 0.
//   The rotations of the very first frame after reset carry no data, so they
//   are suppressed until the first full frame has been seen (primed).
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            asynchronous active-low reset
//   valid_in       din_r/din_i carry a sample this cycle
//   din_r, din_i   input sample, real/imag, 32-bit signed
//   W_R, W_I       twiddle factor in Q16 (65536 = 1.0), sampled with valid_in
//   valid_out      dout_r/dout_i carry a result (registered)
//   dout_r, dout_i result sample, real/imag, 32-bit signed (registered)
//   phase          MSB of the frame counter (0 = fill/rotate, 1 = butterfly)
// ---------------------------------------------------------------------------
module fft_sdf_butterfly #(
  parameter int DELAY = 8,
  parameter int SCALE = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic signed [31:0] din_r,
  input  logic signed [31:0] din_i,
  input  logic signed [31:0] W_R,
  input  logic signed [31:0] W_I,
  output logic               valid_out,
  output logic signed [31:0] dout_r,
  output logic signed [31:0] dout_i,
  output logic               phase
);

  localparam int            CW       = $clog2(2 * DELAY);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * DELAY - 1);

  // Q16 product term a*b +/- c*e, evaluated without overflow, rounded
  // half-up (+0.5 LSB) before the 16-bit arithmetic shift. The final
  // truncation to 32 bits keeps bits [47:16] of the 65-bit accumulator.
  function automatic logic signed [31:0] q16_mac(
    input logic signed [31:0] a,
    input logic signed [31:0] b,
    input logic signed [31:0] c,
    input logic signed [31:0] e,
    input logic               sub
  );
    logic signed [63:0] p0;
    logic signed [63:0] p1;
    logic signed [64:0] acc;
    p0 = 64'(a) * 64'(b);
    p1 = 64'(c) * 64'(e);
    if (sub) begin
      acc = 65'(p0) - 65'(p1) + 65'sd32768;
    end else begin
      acc = 65'(p0) + 65'(p1) + 65'sd32768;
    end
    return acc[47:16];
  endfunction

  logic [CW-1:0]      cnt_r;
  logic               primed_r;
  logic               valid_out_r;
  logic signed [31:0] dout_r_r;
  logic signed [31:0] dout_i_r;
  logic signed [31:0] dl_re_r [DELAY];
  logic signed [31:0] dl_im_r [DELAY];

  logic               phase_s;
  logic signed [31:0] d_re_s;
  logic signed [31:0] d_im_s;
  logic signed [32:0] sum_re_s;
  logic signed [32:0] sum_im_s;
  logic signed [32:0] dif_re_s;
  logic signed [32:0] dif_im_s;
  logic signed [31:0] bf_sum_re_s;
  logic signed [31:0] bf_sum_im_s;
  logic signed [31:0] bf_dif_re_s;
  logic signed [31:0] bf_dif_im_s;
  logic signed [31:0] res_re_s;
  logic signed [31:0] res_im_s;
  logic signed [31:0] push_re_s;
  logic signed [31:0] push_im_s;

  assign phase_s = cnt_r[CW-1];
  // Oldest entry of the delay line: the sample pushed DELAY accepted samples ago.
  assign d_re_s  = dl_re_r[DELAY-1];
  assign d_im_s  = dl_im_r[DELAY-1];

  // Butterfly, rotation and selection of the emitted and recirculated values
  always_comb begin
    sum_re_s = 33'(d_re_s) + 33'(din_r);
    sum_im_s = 33'(d_im_s) + 33'(din_i);
    dif_re_s = 33'(d_re_s) - 33'(din_r);
    dif_im_s = 33'(d_im_s) - 33'(din_i);
    bf_sum_re_s = sum_re_s[31:0];
    bf_sum_im_s = sum_im_s[31:0];
    bf_dif_re_s = dif_re_s[31:0];
    bf_dif_im_s = dif_im_s[31:0];
    res_re_s  = 32'sd0;
    res_im_s  = 32'sd0;
    push_re_s = 32'sd0;
    push_im_s = 32'sd0;
    // Scaled mode keeps the 33-bit result in range by halving it.
    if (SCALE == 1) begin
      bf_sum_re_s = sum_re_s[32:1];
      bf_sum_im_s = sum_im_s[32:1];
      bf_dif_re_s = dif_re_s[32:1];
      bf_dif_im_s = dif_im_s[32:1];
    end else begin
      bf_sum_re_s = sum_re_s[31:0];
      bf_sum_im_s = sum_im_s[31:0];
      bf_dif_re_s = dif_re_s[31:0];
      bf_dif_im_s = dif_im_s[31:0];
    end
    if (phase_s) begin
      res_re_s  = bf_sum_re_s;
      res_im_s  = bf_sum_im_s;
      push_re_s = bf_dif_re_s;
      push_im_s = bf_dif_im_s;
    end else begin
      res_re_s  = q16_mac(d_re_s, W_R, d_im_s, W_I, 1'b1);
      res_im_s  = q16_mac(d_re_s, W_I, d_im_s, W_R, 1'b0);
      push_re_s = din_r;
      push_im_s = din_i;
    end
  end

  // Frame counter, primed flag, delay line and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r       <= '0;
      primed_r    <= 1'b0;
      valid_out_r <= 1'b0;
      dout_r_r    <= 32'sd0;
      dout_i_r    <= 32'sd0;
      for (int i = 0; i < DELAY; i++) begin
        dl_re_r[i] <= 32'sd0;
        dl_im_r[i] <= 32'sd0;
      end
    end else if (valid_in) begin
      // 2*DELAY is a power of two, so the natural wrap ends the frame.
      cnt_r <= cnt_r + CW'(1);
      if (cnt_r == CNT_LAST) begin
        primed_r <= 1'b1;
      end
      // Phase-0 outputs of the first frame rotate empty entries: suppress.
      valid_out_r <= phase_s | primed_r;
      dout_r_r    <= res_re_s;
      dout_i_r    <= res_im_s;
      // One push per pop keeps the line at exactly DELAY entries.
      for (int i = DELAY - 1; i > 0; i--) begin
        dl_re_r[i] <= dl_re_r[i-1];
        dl_im_r[i] <= dl_im_r[i-1];
      end
      dl_re_r[0] <= push_re_s;
      dl_im_r[0] <= push_im_s;
    end else begin
      valid_out_r <= 1'b0;
    end
  end

  assign valid_out = valid_out_r;
  assign dout_r    = dout_r_r;
  assign dout_i    = dout_i_r;
  assign phase     = phase_s;

endmodule
